// File: rtl/trivium_pkg.sv
// Shared Trivium constants: state width, register boundaries, tap positions
// (1-based, matching the published cipher description) and FSM encodings.
package trivium_pkg;

  localparam int STATE_W = 288;

  localparam int R1_END = 93;
  localparam int R2_END = 177;
  localparam int R3_END = 288;

  localparam int T1_OUT_A = 66;
  localparam int T1_OUT_B = 93;
  localparam int T2_OUT_A = 162;
  localparam int T2_OUT_B = 177;
  localparam int T3_OUT_A = 243;
  localparam int T3_OUT_B = 288;

  localparam int T1_AND_A = 91;
  localparam int T1_AND_B = 92;
  localparam int T1_FB    = 171;
  localparam int T2_AND_A = 175;
  localparam int T2_AND_B = 176;
  localparam int T2_FB    = 264;
  localparam int T3_AND_A = 286;
  localparam int T3_AND_B = 287;
  localparam int T3_FB    = 69;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  typedef logic [STATE_W-1:0] trivium_state_t;

endpackage

// File: rtl/trivium_round.sv
// One combinational Trivium round: produces the keystream bit z and the
// shifted state. Bit i of the vector holds s(i+1).
module trivium_round
  import trivium_pkg::*;
(
  input  trivium_state_t state_i,
  output trivium_state_t state_o,
  output logic           z_o
);

  logic t1, t2, t3;

  always_comb begin
    t1  = state_i[T1_OUT_A-1] ^ state_i[T1_OUT_B-1];
    t2  = state_i[T2_OUT_A-1] ^ state_i[T2_OUT_B-1];
    t3  = state_i[T3_OUT_A-1] ^ state_i[T3_OUT_B-1];
    z_o = t1 ^ t2 ^ t3;
    t1  = t1 ^ (state_i[T1_AND_A-1] & state_i[T1_AND_B-1]) ^ state_i[T1_FB-1];
    t2  = t2 ^ (state_i[T2_AND_A-1] & state_i[T2_AND_B-1]) ^ state_i[T2_FB-1];
    t3  = t3 ^ (state_i[T3_AND_A-1] & state_i[T3_AND_B-1]) ^ state_i[T3_FB-1];
    // The three registers shift as one 288-bit vector; only their heads take feedback.
    state_o         = {state_i[STATE_W-2:0], 1'b0};
    state_o[0]      = t3;
    state_o[R1_END] = t1;
    state_o[R2_END] = t2;
  end

endmodule

// File: rtl/trivium_stream_xor.sv
// Trivium keystream XOR stage: W rounds per accepted word, 1-cycle registered output.
// Optional TRIVIUM_STREAM_COUNT_EN adds a 32-bit accepted-word counter output.
// Handshake: a word moves on a port when its valid and ready are both high at
// the rising clock edge; out_valid/out_data hold until out_ready.
module trivium_stream_xor
  import trivium_pkg::*;
#(
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [STATE_W-1:0] STR,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_data,
  output logic               loaded,
  output logic [0:0]         dbg_state
`ifdef TRIVIUM_STREAM_COUNT_EN
  ,
  output logic [31:0]        word_count
`endif
);

  logic [0:0]     fsm_q, fsm_d;
  trivium_state_t state_q, state_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           accept;

  logic [W:0][STATE_W-1:0] chain;
  logic [W-1:0]            ks;

  assign chain[0] = state_q;

  for (genvar k = 0; k < W; k++) begin : g_round
    trivium_round u_round (
      .state_i (chain[k]),
      .state_o (chain[k+1]),
      .z_o     (ks[k])
    );
  end

  assign in_ready  = (fsm_q == ST_RUN) && !load && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign loaded    = (fsm_q == ST_RUN);
  assign dbg_state = fsm_q;

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      fsm_d   = ST_RUN;
      state_d = STR;
    end else if (accept) begin
      state_d = chain[W];
    end
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ ks;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q       <= ST_EMPTY;
      state_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef TRIVIUM_STREAM_COUNT_EN
  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (accept) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign word_count = count_q;
`endif

endmodule

// File: tb/tb_trivium_stream_xor.sv
// Scoreboard bench for trivium_stream_xor: a software Trivium model predicts
// each accepted word; a monitor pops and compares every delivered word.
module tb_trivium_stream_xor;

  localparam int W  = 8;
  localparam int SW = 288;

  logic          clk;
  logic          reset;
  logic          load;
  logic [SW-1:0] str;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          loaded;
  logic [0:0]    dbg_state;
`ifdef TRIVIUM_STREAM_COUNT_EN
  logic [31:0]   word_count;
`endif

  trivium_stream_xor #(.W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .STR        (str),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .loaded     (loaded),
    .dbg_state  (dbg_state)
`ifdef TRIVIUM_STREAM_COUNT_EN
    ,
    .word_count (word_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  bit           rs[1:288];
  bit           model_loaded = 1'b0;
  int unsigned  exp_count = 0;
  int           acc_cnt = 0;
  int           pop_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: Trivium as one 288-cell shift register (s1..s288)
  task automatic model_load(input logic [SW-1:0] v);
    for (int i = 1; i <= 288; i++) rs[i] = v[i-1];
  endtask

  task automatic model_clear();
    for (int i = 1; i <= 288; i++) rs[i] = 1'b0;
  endtask

  task automatic model_ks(output logic [W-1:0] ks);
    bit t1, t2, t3;
    for (int k = 0; k < W; k++) begin
      t1 = rs[66] ^ rs[93];
      t2 = rs[162] ^ rs[177];
      t3 = rs[243] ^ rs[288];
      ks[k] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (rs[91] & rs[92]) ^ rs[171];
      t2 = t2 ^ (rs[175] & rs[176]) ^ rs[264];
      t3 = t3 ^ (rs[286] & rs[287]) ^ rs[69];
      for (int i = 288; i > 1; i--) rs[i] = rs[i-1];
      rs[1]   = t3;
      rs[94]  = t1;
      rs[178] = t2;
    end
  endtask

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] v;
    for (int i = 0; i < 9; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Stimulus capture: on each acceptance push the predicted ciphertext
  always begin
    logic [W-1:0] ks;
    @(negedge clk);
    #4;
    if (reset) begin
      if (load) begin
        model_load(str);
        model_loaded = 1'b1;
        exp_count = 0;
      end else if (in_valid && in_ready) begin
        model_ks(ks);
        exp_q.push_back(in_data ^ ks);
        acc_cnt++;
        exp_count++;
      end
    end
  end

  // Monitor: handshake-level checks and scoreboard pop
  always begin
    logic [W-1:0] exp;
    @(negedge clk);
    #3;
    if (reset) begin
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("in_ready", 64'(in_ready),
            64'(model_loaded && !load && (exp_q.size() == 0 || out_ready)));
      check("loaded", 64'(loaded), 64'(model_loaded));
      check("dbg_state", 64'(dbg_state), 64'(model_loaded));
`ifdef TRIVIUM_STREAM_COUNT_EN
      check("word_count", 64'(word_count), 64'(exp_count));
`endif
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(out_data), 64'hdead);
        end else begin
          exp = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(exp));
        end
        pop_cnt++;
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [SW-1:0] v);
    cyc();
    load = 1'b1;
    str = v;
    in_valid = 1'b0;
    #1 check("ready_in_load", 64'(in_ready), 64'd0);
    cyc();
    load = 1'b0;
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    exp_q.delete();
    model_loaded = 1'b0;
    exp_count = 0;
    model_clear();
  endtask

  initial begin
    int a0, p0;
    logic [SW-1:0] v;
    reset = 1'b0;
    load = 1'b0;
    str = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    model_clear();
    repeat (3) cyc();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_loaded", 64'(loaded), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;

    // EMPTY ignores in_valid
    for (int i = 0; i < 4; i++) begin
      cyc();
      in_valid = 1'b1;
      in_data = W'($urandom);
      #1 check("empty_in_ready", 64'(in_ready), 64'd0);
    end
    cyc();
    in_valid = 1'b0;
    check("empty_no_out", 64'(out_valid), 64'd0);

    // Zero state
    do_load('0);
    in_valid = 1'b1;
    in_data = 8'hA5;
    cyc();
    in_valid = 1'b0;
    check("zero_valid", 64'(out_valid), 64'd1);
    check("zero_data", 64'(out_data), 64'hA5);
    cyc();

    // Single tap s66
    v = '0;
    v[65] = 1'b1;
    do_load(v);
    in_valid = 1'b1;
    in_data = 8'h00;
    cyc();
    in_valid = 1'b0;
    check("tap_data", 64'(out_data), 64'h01);
    cyc();

    // Backpressure
    do_load(rand_state());
    p0 = pop_cnt;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = W'($urandom);
    cyc();
    in_data = W'($urandom);
    for (int i = 0; i < 5; i++) begin
      #1 check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_qsize", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() != 0) check("bp_stable", 64'(out_data), 64'(exp_q[0]));
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    check("bp_pops", 64'(pop_cnt - p0), 64'd2);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reload with a word pending
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = W'($urandom);
    do_load(rand_state());
    check("reload_pending", 64'(out_valid), 64'd1);
    if (exp_q.size() != 0) check("reload_data", 64'(out_data), 64'(exp_q[0]));
`ifdef TRIVIUM_STREAM_COUNT_EN
    check("reload_count", 64'(word_count), 64'd0);
`endif
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = W'($urandom);
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();

    // Reset mid-stream
    do_load(rand_state());
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = W'($urandom);
    cyc();
    in_valid = 1'b0;
    assert_reset();
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_loaded", 64'(loaded), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    cyc();
    cyc();
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = W'($urandom);
      #1 check("post_rst_ready", 64'(in_ready), 64'd0);
      check("post_rst_valid", 64'(out_valid), 64'd0);
      cyc();
    end
    in_valid = 1'b0;

    // Throughput: 100 words back to back
    do_load(rand_state());
    a0 = acc_cnt;
    p0 = pop_cnt;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data = W'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    check("thru_accepted", 64'(acc_cnt - a0), 64'd100);
    cyc();
    check("thru_outputs", 64'(pop_cnt - p0), 64'd100);

    // Random traffic with occasional reloads
    for (int i = 0; i < 400; i++) begin
      cyc();
      if ($urandom_range(0, 19) == 0) begin
        load = 1'b1;
        str = rand_state();
      end else begin
        load = 1'b0;
      end
      in_valid = 1'($urandom_range(0, 1));
      in_data = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    cyc();
    load = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
